hazard_ctrl_stage: RTL

- Parametrised successor to the stall-time control zeroing mux.
- Owns the ID/EX control register and the destination-register field.
- Detects load-use hazards and inserts LOAD_LAT bubble cycles, with a counter-driven FSM for multi-cycle load latency.
- Also honours an external stall and a branch flush, and keeps a saturating count of hazard bubbles for performance monitoring.

---
 rtl/hazard_ctrl_stage.sv | 80 ++++++++
 1 files changed

// File: rtl/hazard_ctrl_stage.sv
// ID/EX control register with load-use hazard detection, multi-cycle bubble
// insertion, external stall/flush handling and a saturating bubble counter.
module hazard_ctrl_stage #(
  parameter int CTRL_W       = 10,
  parameter int MEM_READ_BIT = 1,
  parameter int REG_ADDR_W   = 5,
  parameter int LOAD_LAT     = 1,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CTRL_W-1:0]     ctrl_in,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic                  ext_stall,
  input  logic                  flush,
  output logic [CTRL_W-1:0]     ctrl_out,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  stall_out,
  output logic [CNT_W-1:0]      bubble_count
);

  localparam int REM_W = $clog2(LOAD_LAT) + 1;

  typedef enum logic {IDLE, STALL} state_t;

  state_t           state;
  logic [REM_W-1:0] remaining;
  logic             hazard;

  assign hazard = ctrl_out[MEM_READ_BIT] && (ex_rd != '0) &&
                  ((id_rs1_used && (id_rs1 == ex_rd)) ||
                   (id_rs2_used && (id_rs2 == ex_rd)));

  assign stall_out = rst_n && !flush &&
                     (ext_stall || (state == STALL) || hazard);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_out     <= '0;
      ex_rd        <= '0;
      state        <= IDLE;
      remaining    <= '0;
      bubble_count <= '0;
    end else if (flush) begin
      ctrl_out  <= '0;
      ex_rd     <= '0;
      state     <= IDLE;
      remaining <= '0;
    end else if (ext_stall) begin
      ctrl_out  <= ctrl_out;
      ex_rd     <= ex_rd;
    end else if ((state == IDLE) && hazard) begin
      ctrl_out <= '0;
      ex_rd    <= '0;
      if (bubble_count != '1)
        bubble_count <= bubble_count + CNT_W'(1);
      // First bubble is issued here; STALL only covers the remaining LOAD_LAT-1.
      if (LOAD_LAT > 1) begin
        remaining <= REM_W'(LOAD_LAT - 1);
        state     <= STALL;
      end
    end else if (state == STALL) begin
      ctrl_out  <= '0;
      ex_rd     <= '0;
      remaining <= remaining - REM_W'(1);
      if (bubble_count != '1)
        bubble_count <= bubble_count + CNT_W'(1);
      if (remaining == REM_W'(1))
        state <= IDLE;
    end else begin
      ctrl_out <= ctrl_in;
      ex_rd    <= id_rd;
    end
  end

endmodule
